// File: rtl/pattern_gen_pkg.sv
// Shared mode encodings, box direction type and bar colour mapping for pattern_generator.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  // Bar 0 is white and bar 7 black; bit order of the result is {R,G,B}.
  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/box_mover.sv
// One axis of the bouncing box: position ping-pongs between 0 and MAX in STEP
// increments, advancing once per frame tick.
module box_mover
  import pattern_gen_pkg::*;
#(
  parameter int W    = 11,
  parameter int MAX  = 608,
  parameter int STEP = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_tick,
  output logic [W-1:0] o_pos
);

  localparam logic [W:0] MAX_E  = (W+1)'(MAX);
  localparam logic [W:0] STEP_E = (W+1)'(STEP);

  logic [W-1:0] pos_q;
  dir_e         dir_q;
  logic [W:0]   pos_e;
  logic [W:0]   sum_s;

  // One spare bit so pos + STEP cannot wrap before the compare against MAX.
  assign pos_e = {1'b0, pos_q};
  assign sum_s = pos_e + STEP_E;

  // Direction FSM and position register, both advanced only on a frame tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pos_q <= {W{1'b0}};
      dir_q <= DIR_INC;
    end else if (i_tick) begin
      case (dir_q)
        DIR_INC: begin
          if (sum_s >= MAX_E) begin
            pos_q <= MAX_E[W-1:0];
            dir_q <= DIR_DEC;
          end else begin
            pos_q <= sum_s[W-1:0];
          end
        end
        DIR_DEC: begin
          if (pos_e <= STEP_E) begin
            pos_q <= {W{1'b0}};
            dir_q <= DIR_INC;
          end else begin
            pos_q <= pos_q - STEP_E[W-1:0];
          end
        end
        default: begin
          pos_q <= {W{1'b0}};
          dir_q <= DIR_INC;
        end
      endcase
    end
  end

  assign o_pos = pos_q;

endmodule

// File: rtl/pattern_generator.sv
// VGA test-pattern source: bars, checkerboard, gradient and box, registered RGB one
// cycle after the pixel coordinate. Define PATTERN_GEN_BOX_EN for the bouncing box.
module pattern_generator
  import pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int COLOR_W    = 4,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 32,
  parameter int BOX_STEP   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [X_W-1:0]     i_x,
  input  logic [Y_W-1:0]     i_y,
  input  logic [1:0]         i_mode,
  input  logic               i_frame_tick,
  output logic [COLOR_W-1:0] o_red,
  output logic [COLOR_W-1:0] o_green,
  output logic [COLOR_W-1:0] o_blue,
  output logic               o_active
);

  localparam logic [X_W-1:0] BAR_W    = X_W'(H_ACTIVE / 8);
  localparam logic [X_W-1:0] GRAD_DIV = X_W'(H_ACTIVE >> COLOR_W);
  localparam logic [X_W-1:0] GRAD_MAX = X_W'((1 << COLOR_W) - 1);
  localparam logic [X_W-1:0] BAR_LAST = X_W'(7);

  mode_e              mode_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;
  logic               active_q;
  logic [COLOR_W-1:0] red_d, green_d, blue_d;
  logic               active_d;

  logic [X_W-1:0]     bar_idx_s;
  logic [2:0]         bar_sel_s;
  logic [2:0]         bar_c_s;
  logic [X_W-1:0]     grad_s;
  logic [COLOR_W-1:0] grad_val_s;
  logic               cell_s;

  assign active_d   = ({1'b0, i_x} < (X_W+1)'(H_ACTIVE)) && ({1'b0, i_y} < (Y_W+1)'(V_ACTIVE));
  assign bar_idx_s  = i_x / BAR_W;
  assign bar_sel_s  = (bar_idx_s > BAR_LAST) ? 3'd7 : bar_idx_s[2:0];
  assign bar_c_s    = bar_color(bar_sel_s);
  assign grad_s     = i_x / GRAD_DIV;
  assign grad_val_s = (grad_s > GRAD_MAX) ? GRAD_MAX[COLOR_W-1:0] : grad_s[COLOR_W-1:0];
  assign cell_s     = i_x[CHECK_LOG2] ^ i_y[CHECK_LOG2];

`ifdef PATTERN_GEN_BOX_EN
  logic [X_W-1:0] bx_s;
  logic [Y_W-1:0] by_s;
  logic [X_W:0]   x_e, bx_e;
  logic [Y_W:0]   y_e, by_e;
  logic           box_in_s;

  box_mover #(.W(X_W), .MAX(H_ACTIVE - BOX_SIZE), .STEP(BOX_STEP)) u_box_x (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (i_frame_tick),
    .o_pos   (bx_s)
  );

  box_mover #(.W(Y_W), .MAX(V_ACTIVE - BOX_SIZE), .STEP(BOX_STEP)) u_box_y (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (i_frame_tick),
    .o_pos   (by_s)
  );

  assign x_e      = {1'b0, i_x};
  assign y_e      = {1'b0, i_y};
  assign bx_e     = {1'b0, bx_s};
  assign by_e     = {1'b0, by_s};
  assign box_in_s = (x_e >= bx_e) && (x_e < bx_e + (X_W+1)'(BOX_SIZE)) &&
                    (y_e >= by_e) && (y_e < by_e + (Y_W+1)'(BOX_SIZE));
`endif

  // Colour selection for the current pixel; everything outside the active area is black.
  always_comb begin
    red_d   = {COLOR_W{1'b0}};
    green_d = {COLOR_W{1'b0}};
    blue_d  = {COLOR_W{1'b0}};
    if (active_d) begin
      case (mode_q)
        MODE_BARS: begin
          red_d   = {COLOR_W{bar_c_s[2]}};
          green_d = {COLOR_W{bar_c_s[1]}};
          blue_d  = {COLOR_W{bar_c_s[0]}};
        end
        MODE_CHECK: begin
          red_d   = {COLOR_W{cell_s}};
          green_d = {COLOR_W{cell_s}};
          blue_d  = {COLOR_W{cell_s}};
        end
        MODE_GRAD: begin
          green_d = grad_val_s;
        end
        MODE_BOX: begin
`ifdef PATTERN_GEN_BOX_EN
          red_d = {COLOR_W{box_in_s}};
`else
          blue_d = {COLOR_W{1'b1}};
`endif
        end
        default: begin
          red_d = {COLOR_W{1'b0}};
        end
      endcase
    end else begin
      red_d   = {COLOR_W{1'b0}};
      green_d = {COLOR_W{1'b0}};
      blue_d  = {COLOR_W{1'b0}};
    end
  end

  // Output pipeline stage plus the frame-synchronous mode latch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      red_q    <= {COLOR_W{1'b0}};
      green_q  <= {COLOR_W{1'b0}};
      blue_q   <= {COLOR_W{1'b0}};
      active_q <= 1'b0;
      mode_q   <= MODE_BARS;
    end else begin
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      active_q <= active_d;
      if (i_frame_tick) begin
        mode_q <= mode_e'(i_mode);
      end
    end
  end

  assign o_red    = red_q;
  assign o_green  = green_q;
  assign o_blue   = blue_q;
  assign o_active = active_q;

endmodule
